// File: rtl/ram_pkg.sv
// Shared constants and word/address types for the small register-file RAMs.
package ram_pkg;

  localparam int unsigned RAM_WIDTH    = 16;
  localparam int unsigned RAM_DEPTH    = 8;
  localparam int unsigned RAM_ADDR_BUS = 3;

  typedef logic [RAM_WIDTH-1:0]    ram_word_t;
  typedef logic [RAM_ADDR_BUS-1:0] ram_addr_t;

endpackage : ram_pkg

// File: rtl/ram_wr_decode.sv
// Turns a write address plus enable into a one-hot per-word write strobe.
module ram_wr_decode
  import ram_pkg::*;
#(
  parameter int unsigned DEPTH    = RAM_DEPTH,
  parameter int unsigned ADDR_BUS = RAM_ADDR_BUS
) (
  input  logic                we,
  input  logic [ADDR_BUS-1:0] wr_addr,
  output logic [DEPTH-1:0]    wr_strobe
);

  // An unknown enable fails the if-test, so no strobe fires.
  always_comb begin
    wr_strobe = '0;
    if (we) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (wr_addr == ADDR_BUS'(i)) begin
          wr_strobe[i] = 1'b1;
        end
      end
    end
  end

endmodule : ram_wr_decode

// File: rtl/dual_asyn_ram_8x16.sv
// 8x16 RAM: synchronous write port, combinational read port.
// Define DUAL_ASYN_RAM_BYPASS_EN for write-to-read forwarding on address match.
module dual_asyn_ram_8x16
  import ram_pkg::*;
#(
  parameter int unsigned WIDTH    = RAM_WIDTH,
  parameter int unsigned DEPTH    = RAM_DEPTH,
  parameter int unsigned ADDR_BUS = RAM_ADDR_BUS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic                re,
  input  logic [ADDR_BUS-1:0] wr_addr,
  input  logic [ADDR_BUS-1:0] rd_addr,
  input  logic [WIDTH-1:0]    din,
  output logic [WIDTH-1:0]    dout
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] wr_strobe;

  ram_wr_decode #(
    .DEPTH    (DEPTH),
    .ADDR_BUS (ADDR_BUS)
  ) u_wr_decode (
    .we        (we),
    .wr_addr   (wr_addr),
    .wr_strobe (wr_strobe)
  );

  // Storage array; reset clears every word and blocks writes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (wr_strobe[i]) begin
          mem[i] <= din;
        end
      end
    end
  end

  // Combinational read mux, zero when disabled or in reset.
  always_comb begin
    dout = '0;
    if (rst && re) begin
      dout = mem[rd_addr];
`ifdef DUAL_ASYN_RAM_BYPASS_EN
      if (we && (wr_addr == rd_addr)) begin
        dout = din;
      end
`endif
    end
  end

endmodule : dual_asyn_ram_8x16

// File: tb/tb_dual_asyn_ram_8x16.sv
// Directed self-checking bench for dual_asyn_ram_8x16.
module tb_dual_asyn_ram_8x16;

  logic        clk;
  logic        rst;
  logic        we;
  logic        re;
  logic [2:0]  wr_addr;
  logic [2:0]  rd_addr;
  logic [15:0] din;
  logic [15:0] dout;

  int vectors;
  int miscompares;

  dual_asyn_ram_8x16 dut (
    .clk     (clk),
    .rst     (rst),
    .we      (we),
    .re      (re),
    .wr_addr (wr_addr),
    .rd_addr (rd_addr),
    .din     (din),
    .dout    (dout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic do_write(input logic [2:0] addr, input logic [15:0] data);
    @(negedge clk);
    we      = 1'b1;
    wr_addr = addr;
    din     = data;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  task automatic test_reset;
    logic [15:0] exp;
    // Reset state with read enabled
    re = 1'b1;
    rd_addr = 3'd4;
    #1;
    vectors++;
    if (dout !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_state: dout=%h expected=%h", dout, 16'h0000);
    end
    // Write attempted while reset is low is blocked
    @(negedge clk);
    we = 1'b1; wr_addr = 3'd4; din = 16'hCAFE;
    @(posedge clk);
    #1;
    we = 1'b0;
    rst = 1'b1;
    #1;
    vectors++;
    if (dout !== 16'h0000) begin
      miscompares++;
      $display("FAIL write_in_reset: dout=%h expected=%h", dout, 16'h0000);
    end
    // Fill with FFFF then assert reset mid-cycle
    for (int i = 0; i < 8; i++) do_write(3'(i), 16'hFFFF);
    @(negedge clk);
    rd_addr = 3'd6;
    #1;
    vectors++;
    if (dout !== 16'hFFFF) begin
      miscompares++;
      $display("FAIL fill_check: dout=%h expected=%h", dout, 16'hFFFF);
    end
    #1;
    rst = 1'b0;
    #1;
    vectors++;
    if (dout !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_async_dout: dout=%h expected=%h", dout, 16'h0000);
    end
    rst = 1'b1;
    exp = 16'h0000;
    for (int i = 0; i < 8; i++) begin
      rd_addr = 3'(i);
      #1;
      vectors++;
      if (dout !== exp) begin
        miscompares++;
        $display("FAIL reset_clear addr=%0d: dout=%h expected=%h", i, dout, exp);
      end
    end
  endtask

  task automatic test_write_read;
    do_write(3'b101, 16'h3524);
    re = 1'b1;
    rd_addr = 3'b101;
    #1;
    vectors++;
    if (dout !== 16'h3524) begin
      miscompares++;
      $display("FAIL write_read: dout=%h expected=%h", dout, 16'h3524);
    end
  endtask

  task automatic test_read_disable;
    re = 1'b0;
    #1;
    vectors++;
    if (dout !== 16'h0000) begin
      miscompares++;
      $display("FAIL read_disable: dout=%h expected=%h", dout, 16'h0000);
    end
    re = 1'b1;
  endtask

  task automatic test_independence;
    do_write(3'd7, 16'h1234);
    @(negedge clk);
    re = 1'b1; rd_addr = 3'd7;
    we = 1'b1; wr_addr = 3'd0; din = 16'hA5A5;
    #1;
    vectors++;
    if (dout !== 16'h1234) begin
      miscompares++;
      $display("FAIL indep_before: dout=%h expected=%h", dout, 16'h1234);
    end
    @(posedge clk);
    #1;
    we = 1'b0;
    vectors++;
    if (dout !== 16'h1234) begin
      miscompares++;
      $display("FAIL indep_after: dout=%h expected=%h", dout, 16'h1234);
    end
    rd_addr = 3'd0;
    #1;
    vectors++;
    if (dout !== 16'hA5A5) begin
      miscompares++;
      $display("FAIL indep_other_port: dout=%h expected=%h", dout, 16'hA5A5);
    end
  endtask

  task automatic test_collision;
    logic [15:0] exp_before;
`ifdef DUAL_ASYN_RAM_BYPASS_EN
    exp_before = 16'hBEEF;
`else
    exp_before = 16'h1357;
`endif
    do_write(3'b010, 16'h1357);
    @(negedge clk);
    re = 1'b1; rd_addr = 3'b010;
    we = 1'b1; wr_addr = 3'b010; din = 16'hBEEF;
    #1;
    vectors++;
    if (dout !== exp_before) begin
      miscompares++;
      $display("FAIL collision_before: dout=%h expected=%h", dout, exp_before);
    end
    @(posedge clk);
    #1;
    we = 1'b0;
    vectors++;
    if (dout !== 16'hBEEF) begin
      miscompares++;
      $display("FAIL collision_after: dout=%h expected=%h", dout, 16'hBEEF);
    end
  endtask

  task automatic test_sweep;
    logic [15:0] exp;
    for (int i = 0; i < 8; i++) do_write(3'(i), 16'(i) * 16'h1111);
    re = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      rd_addr = 3'(i);
      exp = 16'(i) * 16'h1111;
      #1;
      vectors++;
      if (dout !== exp) begin
        miscompares++;
        $display("FAIL sweep addr=%0d: dout=%h expected=%h", i, dout, exp);
      end
    end
    // Same sweep with write disabled must leave contents intact
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      we = 1'b0; wr_addr = 3'(i); din = 16'hDEAD;
      @(posedge clk);
      #1;
    end
    for (int i = 7; i >= 0; i--) begin
      rd_addr = 3'(i);
      exp = 16'(i) * 16'h1111;
      #1;
      vectors++;
      if (dout !== exp) begin
        miscompares++;
        $display("FAIL sweep_we0 addr=%0d: dout=%h expected=%h", i, dout, exp);
      end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b0;
    we = 1'b0;
    re = 1'b0;
    wr_addr = '0;
    rd_addr = '0;
    din = '0;
    test_reset();
    test_write_read();
    test_read_disable();
    test_independence();
    test_collision();
    test_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_dual_asyn_ram_8x16

// File: doc/dual_asyn_ram_8x16.md
# dual_asyn_ram_8x16

Dual-port RAM of 8 words × 16 bits, with one write port and one independent read port.
- Write is synchronous to `clk`.
- Read is asynchronous (combinational from the read address).

It is a small scratch-storage primitive for datapath blocks that need a same-cycle read of a location written on an earlier edge.

## Interface
Parameters:
- `WIDTH`, 16, data word width in bits
- `DEPTH`, 8, number of words
- `ADDR_BUS`, 3, address width; must equal clog2(DEPTH)

Ports (positional order is fixed as listed):
- `clk`  input  1  single clock; writes occur on its rising edge
- `rst`  input  1  reset; asynchronous, active-low
- `we`  input  1  write enable, sampled on rising `clk`
- `re`  input  1  read enable, combinational
- `wr_addr`  input  ADDR_BUS  write address
- `rd_addr`  input  ADDR_BUS  read address
- `din`  input  WIDTH  write data
- `dout`  output  WIDTH  read data

## Operation
- Storage: DEPTH × WIDTH register array `mem`.
- Reset (`rst`=0):
  - Asynchronously clears every `mem` word to 0.
  - Forces `dout` to 0 for as long as `rst` is low.
  - Writes are blocked while `rst` is low.
- Write: on rising `clk` with `rst`=1 and `we`=1, `mem[wr_addr]` ← `din`. With `we`=0 the array is unchanged.
- Read:
  - `dout` = `mem[rd_addr]` when `rst`=1 and `re`=1.
  - `dout` = 0 when `re`=0.
  - Purely combinational; no clock involvement.
- Read and write ports are fully independent; both may be active in the same cycle at different or equal addresses.
- Addresses are always in range (ADDR_BUS bits, DEPTH=2^ADDR_BUS); no wrap or bounds logic is needed.
- X/Z on `we`: the write is suppressed (treated as 0).

## Timing
- Write latency: data is in `mem` immediately after the rising edge that samples `we`=1.
- Read latency: 0 cycles. `dout` follows `rd_addr`, `re` and `mem` combinationally.
- Same-address read during write (without bypass):
  - `dout` shows the old contents until the edge.
  - `dout` shows the new `din` immediately after the edge.
- Reset deassertion mid-operation: the first write can occur on the first rising edge after `rst` goes high.
- Reset asserted mid-cycle: `mem` and `dout` go to 0 without waiting for `clk`.
- Reset values: `dout` = 0; all `mem` words = 0.

## Configuration
- Macro `DUAL_ASYN_RAM_BYPASS_EN`.
- Defined: write-to-read forwarding. When `rst`=1, `re`=1, `we`=1 and `wr_addr`==`rd_addr`, `dout` = `din` combinationally (write-first view) before the edge.
- Undefined (default): no forwarding. `dout` shows stored contents only (read-old-then-new, as in Timing).

## Structure
- Shared package `ram_pkg` holds:
  - default constants `RAM_WIDTH`=16, `RAM_DEPTH`=8, `RAM_ADDR_BUS`=3;
  - typedef `ram_word_t` (logic [RAM_WIDTH-1:0]);
  - typedef `ram_addr_t` (logic [RAM_ADDR_BUS-1:0]).
- One sub-module is natural: `ram_wr_decode`. It converts `wr_addr` plus `we` into a one-hot DEPTH-bit per-word write strobe.
- The array and read mux stay in the top module.

## Test plan
- Reset: drive `rst`=0 mid-cycle after the array has been filled with 16'hFFFF. Required response:
  - `dout`=0 immediately;
  - after `rst`=1 with `re`=1, reading all 8 addresses returns 0.
- Write/read: write 16'h3524 to address 3'b101 (`we`=1, one edge), then `re`=1, `rd_addr`=3'b101. Required response: `dout`=16'h3524 in the same cycle the address is applied.
- Read disable and independence:
  - with `re`=0, `dout`=0 regardless of contents;
  - write 16'hA5A5 to address 0 while reading address 7 (holding 16'h1234) → `dout` stays 16'h1234.
- Same-address collision: write 16'hBEEF to 3'b010 while `rd_addr`=3'b010 and `re`=1.
  - Without the macro: `dout` shows the old value before the edge and 16'hBEEF after it.
  - With `DUAL_ASYN_RAM_BYPASS_EN`: `dout`=16'hBEEF before the edge.
- Full sweep: write address index × 16'h1111 to all 8 addresses, read back in reverse order → each value matches. Then repeat with `we`=0 and different `din` → contents unchanged.
